// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants used by the hint-unpacking datapath and its neighbours.
package dilithium_pkg;
   localparam int K          = 6;
   localparam int OMEGA      = 55;
   localparam int N          = 256;
   localparam int HINT_BYTES = OMEGA + K;
endpackage

// File: rtl/polyveck_unpack_hint_locator.sv
// hint_poly_locator: finds the polynomial that owns hint position j_i,
// which is the lowest p with j_i < cnt[p].
module hint_poly_locator
   import dilithium_pkg::*;
#(
   parameter int K  = dilithium_pkg::K,
   parameter int PW = 3
) (
   input  logic [7:0]     j_i,
   input  logic [K*8-1:0] cnt_i,
   output logic [PW-1:0]  p_o
);

   // Priority scan from the top so the lowest matching polynomial wins.
   always_comb begin
      p_o = PW'(K - 1);
      for (int p = K - 1; p >= 0; p--) begin
         p_o = (j_i < cnt_i[p*8 +: 8]) ? PW'(p) : p_o;
      end
   end

endmodule

// File: rtl/polyveck_unpack_hint.sv
// polyveck_unpack_hint: loads the OMEGA+K byte hint encoding, then scans one index per cycle
// into the K*256 hint vector. Malformed-encoding checks: POLYVECK_UNPACK_HINT_STRICT_CHECK_EN.
module polyveck_unpack_hint
   import dilithium_pkg::*;
#(
   parameter int K     = dilithium_pkg::K,
   parameter int OMEGA = dilithium_pkg::OMEGA
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [7:0]     in_byte,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [K*N-1:0] h_out,
   output logic           done,
   output logic           err,
   output logic           busy
);

   localparam int NB = OMEGA + K;
   localparam int BW = $clog2(NB + 1);
   localparam int IW = $clog2(OMEGA);
   localparam int PW = (K > 1) ? $clog2(K) : 1;
   localparam int HW = $clog2(K * N);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DECODE, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   bcnt_q;
   logic [IW-1:0]   j_q;
   logic [7:0]      idx_q [OMEGA];
   logic [7:0]      cnt_q [K];
   logic [K*N-1:0]  h_q;
   logic [K*8-1:0]  cnt_flat_s;
   logic            accept_s, last_byte_s, last_j_s, in_poly_s, err_final_s;
   logic [PW-1:0]   p_s, pin_s;
   logic [7:0]      j8_s, idx_j_s;
   logic [HW-1:0]   bit_s;

   assign accept_s    = (state_q == S_LOAD) && in_valid;
   assign last_byte_s = accept_s && (bcnt_q == BW'(NB - 1));
   assign last_j_s    = (state_q == S_DECODE) && (j_q == IW'(OMEGA - 1));
   assign pin_s       = PW'(bcnt_q - BW'(OMEGA));
   assign j8_s        = 8'(j_q);
   assign idx_j_s     = idx_q[j_q];
   assign in_poly_s   = j8_s < cnt_q[K-1];
   assign bit_s       = HW'({p_s, idx_j_s});
   assign h_out       = h_q;

   for (genvar g = 0; g < K; g++) begin : g_cnt
      assign cnt_flat_s[g*8 +: 8] = cnt_q[g];
   end

   hint_poly_locator #(.K(K), .PW(PW)) u_locator (
      .j_i   (j8_s),
      .cnt_i (cnt_flat_s),
      .p_o   (p_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = start ? S_LOAD : S_IDLE;
         S_LOAD:   state_d = last_byte_s ? S_DECODE : S_LOAD;
         S_DECODE: state_d = last_j_s ? S_DONE : S_DECODE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state register.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         S_LOAD:   begin in_ready = 1'b1; busy = 1'b1; end
         S_DECODE: busy = 1'b1;
         S_DONE:   begin busy = 1'b1; done = 1'b1; end
         default:  busy = 1'b0;
      endcase
   end

   // Byte counter, scan position and hint vector accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcnt_q <= '0;
         j_q    <= '0;
         h_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  bcnt_q <= '0;
                  j_q    <= '0;
                  h_q    <= '0;
               end
            end
            S_LOAD: begin
               if (accept_s) begin
                  bcnt_q <= bcnt_q + BW'(1);
               end
            end
            S_DECODE: begin
               j_q <= j_q + IW'(1);
               if (in_poly_s) begin
                  h_q[bit_s] <= 1'b1;
               end
               // A rejected encoding must never leak a partial vector downstream.
               if (last_j_s && err_final_s) begin
                  h_q <= '0;
               end
            end
            default: j_q <= j_q;
         endcase
      end
   end

   // Encoding storage, filled in arrival order: indices first, then counts.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         if (bcnt_q < BW'(OMEGA)) begin
            idx_q[IW'(bcnt_q)] <= in_byte;
         end else begin
            cnt_q[pin_s] <= in_byte;
         end
      end
   end

`ifdef POLYVECK_UNPACK_HINT_STRICT_CHECK_EN
   logic       err_q, err_set_s, load_err_s, order_err_s, tail_err_s;
   logic [7:0] first_s, idx_prev_s;

   assign first_s     = (p_s == '0) ? 8'd0 : cnt_q[p_s - PW'(1)];
   assign idx_prev_s  = idx_q[j_q - IW'(1)];
   assign load_err_s  = accept_s && (bcnt_q >= BW'(OMEGA)) &&
                        ((in_byte > 8'(OMEGA)) ||
                         ((pin_s != '0) && (in_byte < cnt_q[pin_s - PW'(1)])));
   assign order_err_s = (state_q == S_DECODE) && in_poly_s && (j_q != '0) &&
                        (j8_s != first_s) && (idx_j_s <= idx_prev_s);
   assign tail_err_s  = (state_q == S_DECODE) && !in_poly_s && (idx_j_s != 8'd0);
   assign err_set_s   = load_err_s || order_err_s || tail_err_s;
   assign err_final_s = err_q || err_set_s;
   assign err         = err_q;

   // Sticky error flag, cleared only by reset or a new start.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if ((state_q == S_IDLE) && start) begin
         err_q <= 1'b0;
      end else if (err_set_s) begin
         err_q <= 1'b1;
      end
   end
`else
   assign err_final_s = 1'b0;
   assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_polyveck_unpack_hint.sv
// Self-checking bench for polyveck_unpack_hint: behavioural hint decoder model plus a per-cycle compare process.
module tb_polyveck_unpack_hint;
   localparam int K     = 6;
   localparam int OMEGA = 55;
   localparam int NB    = OMEGA + K;
   localparam int HB    = K * 256;
   localparam int HUGE  = 1000000000;

   logic          clk = 1'b0;
   logic          rst, start, in_valid, in_ready, done, err, busy;
   logic [7:0]    in_byte;
   logic [HB-1:0] h_out;

   polyveck_unpack_hint #(.K(K), .OMEGA(OMEGA)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_byte  (in_byte),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .h_out    (h_out),
      .done     (done),
      .err      (err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [7:0]    vec_b [NB];
   logic [HB-1:0] m_h, run_h, lit_h;
   logic [HB-1:0] held_h   = '0;
   logic          held_err = 1'b0;
   logic          m_err, run_err, lit_err;
   int            start_cyc = HUGE;
   int            last_cyc  = HUGE;
   bit            chk_en    = 1'b0;
   logic          e_load, e_busy, e_done;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_h(input string nm, input logic [HB-1:0] act, input logic [HB-1:0] exp);
      int d;
      n_tests++;
      if (act !== exp) begin
         d = -1;
         for (int i = 0; i < HB; i++) begin
            if ((act[i] !== exp[i]) && (d < 0)) d = i;
         end
         n_fail++;
         $display("FAIL %s: got %0d ones expected %0d ones, first differing bit %0d (cycle %0d)",
                  nm, $countones(act), $countones(exp), d, cyc);
      end
   endtask

   // Reference decoder: owner of position j is the lowest p with j < cnt[p].
   task automatic model_compute();
      int cnt [K];
      int owner [OMEGA];
      bit e;
      int strict;
      strict = 0;
`ifdef POLYVECK_UNPACK_HINT_STRICT_CHECK_EN
      strict = 1;
`endif
      m_h = '0;
      e   = 1'b0;
      for (int p = 0; p < K; p++) begin
         cnt[p] = int'(vec_b[OMEGA + p]);
         if (cnt[p] > OMEGA) e = 1'b1;
         if ((p > 0) && (cnt[p] < cnt[p-1])) e = 1'b1;
      end
      for (int j = 0; j < OMEGA; j++) begin
         owner[j] = -1;
         for (int p = K - 1; p >= 0; p--) begin
            if (j < cnt[p]) owner[j] = p;
         end
      end
      for (int j = 0; j < OMEGA; j++) begin
         if (j < cnt[K-1]) begin
            m_h[256 * owner[j] + int'(vec_b[j])] = 1'b1;
            if ((j > 0) && (owner[j-1] == owner[j]) && (vec_b[j] <= vec_b[j-1])) e = 1'b1;
         end else if (vec_b[j] != 8'd0) begin
            e = 1'b1;
         end
      end
      if (strict == 0) e = 1'b0;
      if (e) m_h = '0;
      m_err = e;
   endtask

   // Per-cycle compare of handshake, status and result against the expected timeline.
   always @(negedge clk) begin
      if (chk_en) begin
         e_load = (cyc >= start_cyc) && (cyc < last_cyc);
         e_busy = (cyc >= start_cyc) && (cyc <= last_cyc + OMEGA);
         e_done = (cyc == last_cyc + OMEGA);
         chk1("in_ready", in_ready, e_load);
         chk1("busy", busy, e_busy);
         chk1("done", done, e_done);
         if (e_done) begin
            chk_h("h_at_done", h_out, run_h);
            chk1("err_at_done", err, run_err);
            held_h   = run_h;
            held_err = run_err;
         end else if (!e_busy) begin
            chk_h("h_hold", h_out, held_h);
            chk1("err_hold", err, held_err);
         end
      end
      if (rst) begin
         held_h   = '0;
         held_err = 1'b0;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      in_valid  = 1'b0;
      start     = 1'b0;
      start_cyc = HUGE;
      last_cyc  = HUGE;
   endtask

   task automatic run_vec(input int abort_bytes, input int abort_dec, input bit gaps);
      bit acc;
      bit rdy;
      int tmo;
      model_compute();
      run_h   = m_h;
      run_err = m_err;
      start = 1'b1;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      last_cyc  = HUGE;
      start     = 1'b0;
      for (int b = 0; b < NB; b++) begin
         if (b == abort_bytes) begin
            do_reset();
            return;
         end
         acc = 1'b0;
         tmo = 0;
         while (!acc) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_byte  = in_valid ? vec_b[b] : 8'($urandom_range(0, 255));
            start    = (b == 5);
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            acc = in_valid && rdy;
            tmo++;
            if (tmo > 200) begin
               n_tests++;
               n_fail++;
               $display("FAIL accept_timeout: byte %0d not accepted, got no in_ready expected in_ready", b);
               do_reset();
               return;
            end
         end
         if (b == NB - 1) last_cyc = cyc;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      for (int i = 0; i < OMEGA + 3; i++) begin
         if (i == abort_dec) begin
            do_reset();
            return;
         end
         start = (i == 7);
         @(posedge clk);
         #1;
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_byte  = 8'($urandom_range(0, 255));
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic clear_vec();
      for (int i = 0; i < NB; i++) vec_b[i] = 8'h00;
      lit_h   = '0;
      lit_err = 1'b0;
   endtask

   task automatic set_counts(input int c0, input int c1, input int c2,
                             input int c3, input int c4, input int c5);
      vec_b[OMEGA+0] = 8'(c0);
      vec_b[OMEGA+1] = 8'(c1);
      vec_b[OMEGA+2] = 8'(c2);
      vec_b[OMEGA+3] = 8'(c3);
      vec_b[OMEGA+4] = 8'(c4);
      vec_b[OMEGA+5] = 8'(c5);
   endtask

   task automatic pin_and_run(input string nm);
      model_compute();
      chk_h({nm, "_model_h"}, m_h, lit_h);
      chk1({nm, "_model_err"}, m_err, lit_err);
      run_vec(-1, -1, 1'b1);
   endtask

   task automatic gen_rand(input bit corrupt);
      int pos;
      int n;
      int r;
      int got;
      bit used [256];
      pos = 0;
      for (int i = 0; i < NB; i++) vec_b[i] = 8'h00;
      for (int p = 0; p < K; p++) begin
         n = $urandom_range(0, ((OMEGA - pos) < 12) ? (OMEGA - pos) : 12);
         for (int v = 0; v < 256; v++) used[v] = 1'b0;
         got = 0;
         while (got < n) begin
            r = $urandom_range(0, 255);
            if (!used[r]) begin
               used[r] = 1'b1;
               got++;
            end
         end
         for (int v = 0; v < 256; v++) begin
            if (used[v]) begin
               vec_b[pos] = 8'(v);
               pos++;
            end
         end
         vec_b[OMEGA + p] = 8'(pos);
      end
      if (corrupt) vec_b[$urandom_range(0, NB - 1)] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      clear_vec();
      pin_and_run("all_zero");

      clear_vec();
      vec_b[0] = 8'd3;
      vec_b[1] = 8'd200;
      set_counts(2, 2, 2, 2, 2, 2);
      lit_h[3]   = 1'b1;
      lit_h[200] = 1'b1;
      pin_and_run("two_in_p0");

      clear_vec();
      vec_b[0] = 8'd255;
      set_counts(0, 0, 0, 0, 0, 1);
      lit_h[1535] = 1'b1;
      pin_and_run("last_bit");

      clear_vec();
      vec_b[0] = 8'd10;
      vec_b[1] = 8'd10;
      set_counts(0, 2, 2, 2, 2, 2);
`ifdef POLYVECK_UNPACK_HINT_STRICT_CHECK_EN
      lit_err = 1'b1;
`else
      lit_h[266] = 1'b1;
`endif
      pin_and_run("repeat_idx");

      clear_vec();
      vec_b[0] = 8'd10;
      vec_b[1] = 8'd10;
      set_counts(3, 2, 2, 2, 2, 2);
`ifdef POLYVECK_UNPACK_HINT_STRICT_CHECK_EN
      lit_err = 1'b1;
`else
      lit_h[10] = 1'b1;
`endif
      pin_and_run("count_decrease");

      clear_vec();
      vec_b[0] = 8'd10;
      vec_b[1] = 8'd10;
      set_counts(0, 2, 2, 2, 2, 56);
`ifdef POLYVECK_UNPACK_HINT_STRICT_CHECK_EN
      lit_err = 1'b1;
`else
      lit_h[266]  = 1'b1;
      lit_h[1280] = 1'b1;
`endif
      pin_and_run("count_over");

      clear_vec();
      vec_b[0] = 8'd7;
      vec_b[1] = 8'd1;
      set_counts(1, 1, 1, 1, 1, 1);
`ifdef POLYVECK_UNPACK_HINT_STRICT_CHECK_EN
      lit_err = 1'b1;
`else
      lit_h[7] = 1'b1;
`endif
      pin_and_run("nonzero_tail");

      gen_rand(1'b0);
      run_vec(20, -1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      run_vec(-1, -1, 1'b0);

      gen_rand(1'b0);
      run_vec(-1, 20, 1'b1);
      run_vec(-1, -1, 1'b1);

      for (int t = 0; t < 14; t++) begin
         gen_rand(t % 3 == 2);
         run_vec(-1, -1, 1'b1);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/polyveck_unpack_hint.md
POLYVECK_UNPACK_HINT -- requirements
Module: polyveck_unpack_hint

Interface
REQ-001 Parameter K, default 6, number of polynomials in the hint vector.
REQ-002 Parameter OMEGA, default 55, maximum total hint ones and size of the index field.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: begin a new unpack; honoured only in IDLE.
REQ-006 Port in_byte, input, 8 bits: hint encoding byte stream; OMEGA index bytes first, then K cumulative count bytes (OMEGA+K bytes total).
REQ-007 Port in_valid, input, 1 bit: in_byte is valid this cycle.
REQ-008 Port in_ready, output, 1 bit: block accepts in_byte; a byte transfers when in_valid and in_ready are both high.
REQ-009 Port h_out, output, K*256 bits: hint bit vector; bit 256*p+i is hint coefficient i of polynomial p; feeds polyveck_use_hint h_in.
REQ-010 Port done, output, 1 bit: one-cycle pulse when h_out and err are final.
REQ-011 Port err, output, 1 bit: malformed encoding detected; sticky until next start or reset.
REQ-012 Port busy, output, 1 bit: high in LOAD, DECODE and DONE.

Function
REQ-013 States IDLE, LOAD, DECODE and DONE are required: IDLE->LOAD on start; LOAD->DECODE on acceptance of byte OMEGA+K-1; DECODE->DONE after OMEGA cycles; DONE->IDLE after one cycle.
REQ-014 On start in IDLE, h_out and err shall clear to 0 and the byte counter shall clear to 0.
REQ-015 in_ready shall be high only in LOAD; bytes shall be stored in arrival order; in_valid gaps shall stall LOAD with no state change.
REQ-016 Count bytes shall be checked as they arrive: cnt[p] < cnt[p-1] (p>0) or cnt[p] > OMEGA shall set err.
REQ-017 DECODE shall scan index position j = 0..OMEGA-1, one per cycle; the owning polynomial is the lowest p with j < cnt[p].
REQ-018 When j < cnt[K-1], bit 256*p + idx[j] of h_out shall be set.
REQ-019 When j is not the first position of polynomial p and idx[j] <= idx[j-1], err shall be set (strictly increasing rule).
REQ-020 When j >= cnt[K-1] and idx[j] != 0, err shall be set (zero-tail rule).
REQ-021 Latency: done shall pulse exactly OMEGA+1 cycles after the cycle the last byte is accepted.
REQ-022 When err is high at DONE, h_out shall be driven to all-zero; otherwise h_out shall hold the decoded vector.
REQ-023 h_out and err shall hold their values after DONE until the next start or reset.
REQ-024 start outside IDLE shall be ignored.

Reset
REQ-025 rst high at a clock edge shall force IDLE; h_out, done, err, busy and in_ready shall all be 0 and the byte counter 0, including mid-LOAD or mid-DECODE; partially loaded data shall be discarded.

Configuration
REQ-026 With macro POLYVECK_UNPACK_HINT_STRICT_CHECK_EN defined, the checks of REQ-016, REQ-019, REQ-020 and REQ-022 shall be compiled in.
REQ-027 With the macro undefined, err shall be tied 0 and the check logic absent; REQ-018 decoding and all timing shall be unchanged.

Structure
REQ-028 K, OMEGA, N=256 and HINT_BYTES=OMEGA+K shall come from the shared dilithium package; module parameters shall default to those values.
REQ-029 The state-encoding type shall be local; the package shall hold only cross-block constants.
REQ-030 One sub-module, hint_poly_locator, shall map (j, cnt[0..K-1]) to polynomial index p combinationally.

Verification
REQ-031 All 61 bytes zero -> h_out=0, err=0, done 56 cycles after last byte.
REQ-032 idx0=3, idx1=200, counts 2,2,2,2,2,2 -> h_out bits 3 and 200 set only, err=0.
REQ-033 idx0=255, counts 0,0,0,0,0,1 -> only h_out bit 1535 set, err=0.
REQ-034 idx0=10, idx1=10, counts 0,2,2,2,2,2 -> err=1, h_out=0; repeat with counts 3,2,... and with count 56, each -> err=1.
REQ-035 counts all 1, idx0=7, idx1=1 -> err=1 (tail); macro undefined -> err=0, bit 7 set.
REQ-036 rst asserted after 20 bytes with random in_valid gaps, then full valid stream -> outputs 0 at reset, correct decode afterwards.
